// File: rtl/edge_event_arbiter_if.sv
// Event-port bundle for edge_event_arbiter: monitored lines, enables,
// the valid/ready event handshake and the pending/overflow status.
interface edge_event_arbiter_if #(
   parameter int N = 4
) ();
   localparam int IDX_W = $clog2(N);

   logic [N-1:0]     a;
   logic [N-1:0]     en;
   logic             evt_ready;
   logic             ovf_clr;
   logic             evt_valid;
   logic [IDX_W-1:0] evt_ch;
   logic             evt_rise;
   logic [N-1:0]     pend;
   logic [N-1:0]     overflow;

   // Producer of lines/handshake control, consumer of events
   modport master (
      output a, en, evt_ready, ovf_clr,
      input  evt_valid, evt_ch, evt_rise, pend, overflow
   );

   // The arbiter itself
   modport slave (
      input  a, en, evt_ready, ovf_clr,
      output evt_valid, evt_ch, evt_rise, pend, overflow
   );
endinterface

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge detector that queues rise/fall events per channel and
// serialises them onto one valid/ready port with round-robin arbitration.
module edge_event_arbiter #(
   parameter int N = 4
) (
   input logic                 clk,
   input logic                 rst,
   edge_event_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(N);

   logic [N-1:0]     a_q, a_d;
   logic             primed_q, primed_d;
   logic [N-1:0]     pr_q, pr_d;
   logic [N-1:0]     pf_q, pf_d;
   logic [N-1:0]     fo_q, fo_d;
   logic [N-1:0]     ovf_q, ovf_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             evt_valid_q, evt_valid_d;
   logic [IDX_W-1:0] evt_ch_q, evt_ch_d;
   logic             evt_rise_q, evt_rise_d;

   logic [N-1:0]     pending;
   logic             slot_free;
   logic             found;
   logic             grant;
   logic [IDX_W-1:0] gnt_ch;
   logic             gnt_rise;

   // Round-robin search from ptr; the lowest offset that is pending wins
   always_comb begin
      logic [IDX_W-1:0] cand;
      cand      = '0;
      pending   = pr_q | pf_q;
      slot_free = ~evt_valid_q | bus.evt_ready;
      found     = 1'b0;
      gnt_ch    = '0;
      for (int off = N - 1; off >= 0; off--) begin
         cand = IDX_W'((int'(ptr_q) + off) % N);
         if (pending[cand]) begin
            found  = 1'b1;
            gnt_ch = cand;
         end
      end
      // Only-pending bit, or the older one when both are pending
      gnt_rise = pr_q[gnt_ch] & (~pf_q[gnt_ch] | ~fo_q[gnt_ch]);
      grant    = slot_free & found;
   end

   // Per-channel edge detection, pending bits, age order and overrun
   always_comb begin
      logic r_det, f_det, is_gnt, pr_keep, pf_keep;
      logic [N-1:0] ovf_set;
      r_det   = 1'b0;
      f_det   = 1'b0;
      is_gnt  = 1'b0;
      pr_keep = 1'b0;
      pf_keep = 1'b0;
      ovf_set = '0;
      pr_d    = pr_q;
      pf_d    = pf_q;
      fo_d    = fo_q;
      for (int i = 0; i < N; i++) begin
         r_det   = primed_q & bus.en[i] & bus.a[i] & ~a_q[i];
         f_det   = primed_q & bus.en[i] & ~bus.a[i] & a_q[i];
         is_gnt  = grant & (gnt_ch == IDX_W'(i));
         // Bits that survive this cycle's grant; a granted bit is free to re-set
         pr_keep = pr_q[i] & ~(is_gnt & gnt_rise);
         pf_keep = pf_q[i] & ~(is_gnt & ~gnt_rise);
         pr_d[i] = pr_keep | r_det;
         pf_d[i] = pf_keep | f_det;
         // The bit already waiting becomes the older one
         if (r_det & pf_keep) fo_d[i] = 1'b1;
         if (f_det & pr_keep) fo_d[i] = 1'b0;
         ovf_set[i] = (r_det & pr_keep) | (f_det & pf_keep);
      end
      // A fresh overrun wins over a simultaneous clear
      ovf_d    = ovf_set | (ovf_q & ~{N{bus.ovf_clr}});
      a_d      = bus.a;
      primed_d = 1'b1;
   end

   // Output slot: load on grant when free, drop valid when free and idle
   always_comb begin
      evt_valid_d = evt_valid_q;
      evt_ch_d    = evt_ch_q;
      evt_rise_d  = evt_rise_q;
      ptr_d       = ptr_q;
      if (slot_free) begin
         if (found) begin
            evt_valid_d = 1'b1;
            evt_ch_d    = gnt_ch;
            evt_rise_d  = gnt_rise;
            ptr_d       = IDX_W'((int'(gnt_ch) + 1) % N);
         end else begin
            evt_valid_d = 1'b0;
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q         <= '0;
         primed_q    <= 1'b0;
         pr_q        <= '0;
         pf_q        <= '0;
         fo_q        <= '0;
         ovf_q       <= '0;
         ptr_q       <= '0;
         evt_valid_q <= 1'b0;
         evt_ch_q    <= '0;
         evt_rise_q  <= 1'b0;
      end else begin
         a_q         <= a_d;
         primed_q    <= primed_d;
         pr_q        <= pr_d;
         pf_q        <= pf_d;
         fo_q        <= fo_d;
         ovf_q       <= ovf_d;
         ptr_q       <= ptr_d;
         evt_valid_q <= evt_valid_d;
         evt_ch_q    <= evt_ch_d;
         evt_rise_q  <= evt_rise_d;
      end
   end

   assign bus.evt_valid = evt_valid_q;
   assign bus.evt_ch    = evt_ch_q;
   assign bus.evt_rise  = evt_rise_q;
   assign bus.pend      = pr_q | pf_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomised bench for edge_event_arbiter against a queue-based model:
// each channel holds an ordered list of pending edge types (oldest first).
module tb_edge_event_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   edge_event_arbiter_if #(.N(N)) bus_if ();

   edge_event_arbiter #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit         pq [N][$];   // per channel: pending edge types, 1 = rise, oldest first
   bit         m_valid;
   int         m_ch;
   bit         m_rise;
   int         m_ptr;
   logic [N-1:0] m_ovf;
   logic [N-1:0] m_a;
   bit         m_primed;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) pq[i].delete();
      m_valid  = 0;
      m_ch     = 0;
      m_rise   = 0;
      m_ptr    = 0;
      m_ovf    = '0;
      m_a      = '0;
      m_primed = 0;
   endtask

   function automatic logic [N-1:0] model_pend();
      logic [N-1:0] p;
      for (int i = 0; i < N; i++) p[i] = (pq[i].size() > 0);
      return p;
   endfunction

   // One clock of the model, using the inputs present at the edge
   task automatic model_step();
      bit found;
      int k;
      bit t;
      logic [N-1:0] nov;
      if (!m_valid || bus_if.evt_ready) begin
         found = 0;
         for (int off = 0; off < N; off++) begin
            k = (m_ptr + off) % N;
            if (!found && pq[k].size() > 0) begin
               found   = 1;
               m_valid = 1;
               m_ch    = k;
               m_rise  = pq[k].pop_front();
               m_ptr   = (k + 1) % N;
            end
         end
         if (!found) m_valid = 0;
      end
      nov = bus_if.ovf_clr ? '0 : m_ovf;
      if (m_primed) begin
         for (int i = 0; i < N; i++) begin
            if (bus_if.en[i] && bus_if.a[i] != m_a[i]) begin
               t = bus_if.a[i];
               for (int j = pq[i].size() - 1; j >= 0; j--) begin
                  if (pq[i][j] == t) begin
                     pq[i].delete(j);
                     nov[i] = 1'b1;
                  end
               end
               pq[i].push_back(t);
            end
         end
      end
      m_ovf    = nov;
      m_a      = bus_if.a;
      m_primed = 1;
   endtask

   task automatic compare_outputs();
      chk_eq("evt_valid", bus_if.evt_valid, m_valid);
      if (m_valid) begin
         chk_eq("evt_ch", bus_if.evt_ch, m_ch);
         chk_eq("evt_rise", bus_if.evt_rise, m_rise);
      end
      chk_eq("pend", bus_if.pend, model_pend());
      chk_eq("overflow", bus_if.overflow, m_ovf);
   endtask

   // Called at a negedge: drive, clock, then check at the next negedge
   task automatic run_cycle(input logic [N-1:0] a_v, input logic [N-1:0] en_v,
                            input logic rdy, input logic clr);
      bus_if.a         = a_v;
      bus_if.en        = en_v;
      bus_if.evt_ready = rdy;
      bus_if.ovf_clr   = clr;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_outputs();
      $display("cyc a=%b en=%b rdy=%0d clr=%0d -> valid=%0d ch=%0d rise=%0d pend=%b ovf=%b",
               a_v, en_v, rdy, clr, bus_if.evt_valid, bus_if.evt_ch, bus_if.evt_rise,
               bus_if.pend, bus_if.overflow);
   endtask

   // Random traffic: rdy_pct = % of cycles ready high, sparse = thin toggles
   task automatic random_phase(input int cycles, input int rdy_pct, input bit sparse,
                               input bit rand_en, input int clr_pct);
      logic [N-1:0] tog, en_v;
      for (int c = 0; c < cycles; c++) begin
         tog = N'($urandom);
         if (sparse) tog = tog & N'($urandom) & N'($urandom);
         en_v = rand_en ? (N'($urandom) | N'($urandom)) : '1;
         run_cycle(bus_if.a ^ tog, en_v, ($urandom_range(99) < rdy_pct),
                   ($urandom_range(99) < clr_pct));
      end
   endtask

   task automatic mid_reset();
      int budget = 0;
      while (!(m_valid && $countones(model_pend()) >= 2) && budget < 60) begin
         run_cycle(bus_if.a ^ N'($urandom), '1, 1'b0, 1'b0);
         budget++;
      end
      chk_eq("midrst_setup", (m_valid && $countones(model_pend()) >= 2), 1);
      #2 rst = 1'b1;
      #1;
      chk_eq("rst_valid", bus_if.evt_valid, 0);
      chk_eq("rst_pend", bus_if.pend, 0);
      chk_eq("rst_ovf", bus_if.overflow, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      // Lines hold still: no events may appear
      for (int c = 0; c < 5; c++) run_cycle(bus_if.a, '1, 1'b1, 1'b0);
   endtask

   initial begin
      bus_if.a         = '1;
      bus_if.en        = '1;
      bus_if.evt_ready = 1'b1;
      bus_if.ovf_clr   = 1'b0;
      model_reset();
      #12;
      @(negedge clk);
      rst = 1'b0;
      compare_outputs();
      // Lines high through reset: priming must swallow them
      for (int c = 0; c < 6; c++) run_cycle(4'b1111, '1, 1'b1, 1'b0);
      run_cycle(4'b0111, '1, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) run_cycle(4'b0111, '1, 1'b1, 1'b0);
      // Simultaneous rises to exercise round-robin order
      run_cycle(4'b0000, '1, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) run_cycle(4'b0000, '1, 1'b1, 1'b0);
      run_cycle(4'b1011, '1, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) run_cycle(4'b1011, '1, 1'b1, 1'b0);
      // Backpressure with a pulse on ch1
      run_cycle(4'b1001, '1, 1'b0, 1'b0);
      run_cycle(4'b1011, '1, 1'b0, 1'b0);
      run_cycle(4'b1001, '1, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) run_cycle(4'b1001, '1, 1'b0, 1'b0);
      for (int c = 0; c < 6; c++) run_cycle(4'b1001, '1, 1'b1, 1'b0);
      random_phase(200, 100, 1'b1, 1'b0, 0);
      random_phase(200, 25, 1'b0, 1'b0, 5);
      random_phase(300, 60, 1'b1, 1'b1, 10);
      mid_reset();
      random_phase(300, 50, 1'b0, 1'b1, 20);
      mid_reset();
      random_phase(200, 80, 1'b1, 1'b1, 5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
